line_clear_engine: RTL
======================

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have parameter ROWS, default 20, board height; row 0 is the bottom row.
REQ-002 SHALL have parameter COLS, default 10, board width.
REQ-003 SHALL have parameter SCORE_W, default 8, score register width.
REQ-004 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  request to process board_i; sampled only in IDLE.
REQ-007 SHALL have port clear_i  input  1  new-game request; zeroes score.
REQ-008 SHALL have port board_i  input  [ROWS-1:0][COLS-1:0]  settled board to process.
REQ-009 SHALL have port board_o  output  [ROWS-1:0][COLS-1:0]  working/result board.
REQ-010 SHALL have port busy_o  output  1  high while an operation is in SCAN or SHIFT.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse when an operation completes.
REQ-012 SHALL have port lines_o  output  $clog2(ROWS+1)  rows cleared by the last operation.
REQ-013 SHALL have port score_o  output  SCORE_W  accumulated score.

Function
REQ-014 SHALL implement states IDLE, SCAN, SHIFT and DONE; only these states exist.
REQ-015 SHALL in IDLE with start_i=1 load board_i into board_o, set row pointer r=0 and lines count k=0, and go to SCAN.
REQ-016 SHALL ignore start_i in any state other than IDLE; no queuing.
REQ-017 SHALL in SCAN test row r: all COLS bits 1 -> SHIFT; else r=r+1; when r=ROWS-1 is tested and not full -> DONE.
REQ-018 SHALL in SHIFT, in one cycle, copy row i+1 to row i for i=r..ROWS-2, zero row ROWS-1, set k=k+1, keep r, and return to SCAN (row r re-tested).
REQ-019 SHALL give latency ROWS+2k cycles in SCAN/SHIFT, then exactly one DONE cycle; done_o rises on cycle ROWS+2k+1 after the start edge.
REQ-020 SHALL assert busy_o in SCAN and SHIFT only; done_o in DONE only; DONE returns to IDLE unconditionally.
REQ-021 SHALL in DONE update lines_o=k and add the operation's points to score_o.
REQ-022 SHALL saturate score_o at 2^SCORE_W-1; no wrap-around.
REQ-023 SHALL on clear_i=1 set score_o=0 next edge in any state; clear_i coincident with DONE yields score_o=0 (clear wins); the operation itself continues unaffected.
REQ-024 SHALL hold board_o, lines_o and score_o stable in IDLE; board_o is valid as result from the DONE cycle onward.
REQ-025 SHALL treat all-full board (k=ROWS) as legal: result all zeros, lines_o=ROWS.

Reset
REQ-026 SHALL on reset low, immediately and regardless of clock: state=IDLE, board_o=0, r=0, k=0, lines_o=0, score_o=0, busy_o=0, done_o=0.
REQ-027 SHALL on reset mid-operation abandon the operation with no score update and no done_o pulse.
REQ-028 SHALL accept start_i on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL use macro LINE_BONUS_EN to select scoring.
REQ-030 SHALL with LINE_BONUS_EN defined add points 0,1,3,5,8 for k=0,1,2,3,>=4.
REQ-031 SHALL without LINE_BONUS_EN add points equal to k.

Verification
REQ-032 SHALL cover empty board, start pulse -> done_o at cycle 21, lines_o=0, board_o=0, score_o unchanged.
REQ-033 SHALL cover rows 0 and 2 full, row 1 = 10'b0000000001, row 3 = 10'b1000000000 -> done_o at cycle 25, lines_o=2, board_o row0=10'b0000000001, row1=10'b1000000000, rest 0; score +3 with LINE_BONUS_EN, +2 without.
REQ-034 SHALL cover all 20 rows full -> done_o at cycle 61, lines_o=20, board_o all zero, score +8 (bonus) or +20.
REQ-035 SHALL cover score_o=254, SCORE_W=8, operation clearing 4 rows with LINE_BONUS_EN -> score_o=255; clear_i in DONE cycle -> score_o=0.
REQ-036 SHALL cover second start_i while busy_o=1 -> ignored, single done_o pulse; reset low mid-SCAN -> all outputs 0 immediately, no done_o.

Source files
------------

// File: rtl/line_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_engine
// Description : Line-clear engine for a falling-block game board. On start_i
//               it loads a settled board, scans rows bottom-up, collapses
//               every full row (rows above drop by one) and, on completion,
//               reports the number of cleared rows and adds points to a
//               saturating score register.
// Configuration:
//               LINE_BONUS_EN defined   -> points 0,1,3,5,8 for k=0,1,2,3,>=4
//               LINE_BONUS_EN undefined -> points equal to rows cleared (k)
// Ports       :
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start_i  in   begin processing board_i (sampled only in IDLE)
//   clear_i  in   new-game request, zeroes the score on the next edge
//   board_i  in   [ROWS-1:0][COLS-1:0] settled board, row 0 = bottom
//   board_o  out  [ROWS-1:0][COLS-1:0] working / result board
//   busy_o   out  high in SCAN and SHIFT
//   done_o   out  one-cycle completion pulse (DONE state)
//   lines_o  out  rows cleared by the last operation
//   score_o  out  accumulated, saturating score
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_engine #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int SCORE_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic                          clear_i,
    input  logic [ROWS-1:0][COLS-1:0]     board_i,
    output logic [ROWS-1:0][COLS-1:0]     board_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(ROWS+1)-1:0]     lines_o,
    output logic [SCORE_W-1:0]            score_o
);

    localparam int KW   = $clog2(ROWS + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW   = (KW > 4) ? KW : 4;
    localparam int SUMW = ((SCORE_W > PW) ? SCORE_W : PW) + 1;

    localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);
    localparam logic [SUMW-1:0] SCORE_MAX = {{(SUMW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q;
    logic [ROWS-1:0][COLS-1:0]   board_q;
    logic [RW-1:0]               r_q;
    logic [KW-1:0]               k_q;
    logic [KW-1:0]               lines_q;
    logic [SCORE_W-1:0]          score_q;
    logic                        busy_q;
    logic                        done_q;

    logic                        row_full_d;
    logic [ROWS-1:0][COLS-1:0]   shift_board_d;
    logic [PW-1:0]               points_d;
    logic [SUMW-1:0]             sum_d;
    logic [SCORE_W-1:0]          sat_score_d;

    // Row under the scan pointer is full when every cell is occupied.
    always_comb begin
        row_full_d = &board_q[r_q];
    end

    // Collapse row r: everything at or above r drops one row; the top row
    // always becomes empty because r never exceeds ROWS-1.
    always_comb begin
        shift_board_d = board_q;
        for (int i = 0; i < ROWS - 1; i++) begin
            if (RW'(i) >= r_q) begin
                shift_board_d[i] = board_q[i+1];
            end
        end
        shift_board_d[ROWS-1] = '0;
    end

    // Points for the operation, derived from the final line count.
    always_comb begin
        points_d = '0;
`ifdef LINE_BONUS_EN
        case (int'(k_q))
            0:       points_d = PW'(0);
            1:       points_d = PW'(1);
            2:       points_d = PW'(3);
            3:       points_d = PW'(5);
            default: points_d = PW'(8);
        endcase
`else
        points_d = PW'(k_q);
`endif
    end

    // Saturating accumulate: the sum is one bit wider than either operand so
    // overflow is detected before truncation.
    always_comb begin
        sum_d       = SUMW'(score_q) + SUMW'(points_d);
        sat_score_d = (sum_d > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_d[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            board_q <= '0;
            r_q     <= '0;
            k_q     <= '0;
            lines_q <= '0;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        board_q <= board_i;
                        r_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (row_full_d) begin
                        state_q <= S_SHIFT;
                    end else if (r_q == LAST_ROW) begin
                        // Results are registered on entry so they are
                        // visible during the DONE cycle itself.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lines_q <= k_q;
                        score_q <= sat_score_d;
                        state_q <= S_DONE;
                    end else begin
                        r_q <= r_q + RW'(1);
                    end
                end
                S_SHIFT: begin
                    // r is kept so the row that dropped into place is re-tested.
                    board_q <= shift_board_d;
                    k_q     <= k_q + KW'(1);
                    state_q <= S_SCAN;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // New-game clear has priority over any score update.
            if (clear_i) begin
                score_q <= '0;
            end
        end
    end

    assign board_o = board_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign lines_o = lines_q;
    assign score_o = score_q;

endmodule
`default_nettype wire
